// File: rtl/ksz8851_bus_ctrl_if.sv
// ksz8851_bus_ctrl_if
//   Bundles the request/response handshake and the KSZ8851 host-bus pins
//   that ksz8851_bus_ctrl drives and observes.
//   Host side : req_valid/req_ready/req_write/req_addr/req_be/req_wdata,
//               rsp_valid/rsp_rdata, irq
//   Bus side  : CSN, CMD, RDN, WRN, SD_o/SD_oe (drive), SD_i (sample), INTRN
//   The SD tri-state pad lives at the chip top: SD = SD_oe ? SD_o : 'z.
//   slave  : the bus engine
//   master : the requester / surrounding logic
interface ksz8851_bus_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [7:0]  req_addr;
  logic [3:0]  req_be;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        irq;
  logic        CSN;
  logic        CMD;
  logic        RDN;
  logic        WRN;
  logic [15:0] SD_o;
  logic        SD_oe;
  logic [15:0] SD_i;
  logic        INTRN;

  modport slave (
    input  req_valid, req_write, req_addr, req_be, req_wdata, SD_i, INTRN,
    output req_ready, rsp_valid, rsp_rdata, irq,
           CSN, CMD, RDN, WRN, SD_o, SD_oe
  );

  modport master (
    output req_valid, req_write, req_addr, req_be, req_wdata, SD_i, INTRN,
    input  req_ready, rsp_valid, rsp_rdata, irq,
           CSN, CMD, RDN, WRN, SD_o, SD_oe
  );
endinterface

// File: rtl/ksz8851_bus_ctrl.sv
// ksz8851_bus_ctrl
//   Host-bus cycle engine for the KSZ8851 16-bit asynchronous bus. Each
//   accepted register request becomes a command (address) write phase
//   followed by a data write or data read phase, with programmable strobe
//   widths and idle gaps. All bus outputs come straight from flops.
// Ports
//   clk40m : 40 MHz system clock
//   RST    : asynchronous active-high reset
//   bus    : ksz8851_bus_ctrl_if.slave (request/response + bus pins + INTRN)
// Parameters
//   T_WR  : WRN low width, command and data write phases (1..15)
//   T_RD  : RDN low width; SD_i sampled on the last RDN-low cycle (1..15)
//   T_GAP : idle cycles between phases and after the data phase (1..15)
module ksz8851_bus_ctrl #(
  parameter int T_WR  = 2,
  parameter int T_RD  = 2,
  parameter int T_GAP = 1
) (
  input  logic                clk40m,
  input  logic                RST,
  ksz8851_bus_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE, CMD_WR, CMD_HOLD, GAP, DATA_WR, DATA_RD, RECOVER
  } state_t;

  localparam logic [3:0] WR_LAST  = 4'(T_WR - 1);
  localparam logic [3:0] RD_LAST  = 4'(T_RD - 1);
  localparam logic [3:0] GAP_LAST = 4'(T_GAP - 1);

  // Command word: byte enables on top, dword-aligned address at the bottom.
  function automatic logic [15:0] cmd_word(input logic [3:0] be, input logic [7:0] addr);
    return {be, 4'b0000, addr & 8'hFC};
  endfunction

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        wr_q, wr_next;
  logic [15:0] cmd_q, cmd_next;
  logic [15:0] wdata_q, wdata_next;
  logic        accept;

  logic        cmd_n, rdn_n, wrn_n, oe_n;
  logic [15:0] sdo_n;
  logic        irq_meta;

  assign accept  = (state == IDLE) && bus.req_valid;
  assign bus.CSN = 1'b0;

  // Next state, dwell counter, and the bus pin values for the next state.
  // Pins are decoded from state_next and registered so they never glitch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + 4'd1;
    wr_next    = accept ? bus.req_write : wr_q;
    cmd_next   = accept ? cmd_word(bus.req_be, bus.req_addr) : cmd_q;
    wdata_next = accept ? bus.req_wdata : wdata_q;

    case (state)
      IDLE: begin
        cnt_next = 4'd0;
        if (accept) state_next = CMD_WR;
      end
      CMD_WR: if (cnt == WR_LAST) begin
        state_next = CMD_HOLD;
        cnt_next   = 4'd0;
      end
      CMD_HOLD: begin
        state_next = GAP;
        cnt_next   = 4'd0;
      end
      GAP: if (cnt == GAP_LAST) begin
        state_next = wr_q ? DATA_WR : DATA_RD;
        cnt_next   = 4'd0;
      end
      DATA_WR: if (cnt == WR_LAST) begin
        state_next = RECOVER;
        cnt_next   = 4'd0;
      end
      DATA_RD: if (cnt == RD_LAST) begin
        state_next = RECOVER;
        cnt_next   = 4'd0;
      end
      RECOVER: if (cnt == GAP_LAST) begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase

    cmd_n = 1'b0;
    rdn_n = 1'b1;
    wrn_n = 1'b1;
    oe_n  = 1'b0;
    sdo_n = wdata_next;
    case (state_next)
      IDLE: begin
        cmd_n = 1'b1;
        sdo_n = bus.SD_o;
      end
      CMD_WR: begin
        cmd_n = 1'b1;
        wrn_n = 1'b0;
        oe_n  = 1'b1;
        sdo_n = cmd_next;
      end
      CMD_HOLD: begin
        cmd_n = 1'b1;
        oe_n  = 1'b1;
        sdo_n = cmd_next;
      end
      // Reads release the bus here so the chip can turn it around.
      GAP, RECOVER: oe_n = wr_next;
      DATA_WR: begin
        wrn_n = 1'b0;
        oe_n  = 1'b1;
      end
      DATA_RD: rdn_n = 1'b0;
      default: cmd_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk40m or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      wr_q          <= 1'b0;
      cmd_q         <= 16'h0000;
      wdata_q       <= 16'h0000;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 16'h0000;
      bus.CMD       <= 1'b1;
      bus.RDN       <= 1'b1;
      bus.WRN       <= 1'b1;
      bus.SD_o      <= 16'h0000;
      bus.SD_oe     <= 1'b0;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      wr_q          <= wr_next;
      cmd_q         <= cmd_next;
      wdata_q       <= wdata_next;
      bus.req_ready <= (state_next == IDLE);
      bus.rsp_valid <= (state == RECOVER) && (state_next == IDLE);
      // Sample read data on the edge that ends the RDN-low window.
      if ((state == DATA_RD) && (cnt == RD_LAST))
        bus.rsp_rdata <= bus.SD_i;
      bus.CMD       <= cmd_n;
      bus.RDN       <= rdn_n;
      bus.WRN       <= wrn_n;
      bus.SD_o      <= sdo_n;
      bus.SD_oe     <= oe_n;
    end
  end

  // Two-flop synchronizer for the asynchronous active-low interrupt.
  always_ff @(posedge clk40m or posedge RST) begin
    if (RST) begin
      irq_meta <= 1'b0;
      bus.irq  <= 1'b0;
    end else begin
      irq_meta <= ~bus.INTRN;
      bus.irq  <= irq_meta;
    end
  end

endmodule

// File: tb/tb_ksz8851_bus_ctrl.sv
// tb_ksz8851_bus_ctrl
//   Directed bench for ksz8851_bus_ctrl with default timing (T_WR=2, T_RD=2,
//   T_GAP=1). A simple bus model returns rd_val on SD_i while RDN is low.
module tb_ksz8851_bus_ctrl;
  logic clk40m = 1'b0;
  logic RST    = 1'b1;
  logic [15:0] rd_val = 16'h0000;
  int n_chk  = 0;
  int n_fail = 0;

  ksz8851_bus_ctrl_if bus ();

  ksz8851_bus_ctrl #(.T_WR(2), .T_RD(2), .T_GAP(1)) dut (
    .clk40m (clk40m),
    .RST    (RST),
    .bus    (bus.slave)
  );

  always #5 clk40m = ~clk40m;

  assign bus.SD_i = (bus.RDN == 1'b0) ? rd_val : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks {CMD,WRN,RDN,SD_oe} and, when asked, SD_o.
  task automatic chk_bus(input string tag, input logic [3:0] pins,
                         input logic [15:0] sdo, input bit use_sdo);
    chk({tag, "_pins"}, {28'h0, bus.CMD, bus.WRN, bus.RDN, bus.SD_oe}, {28'h0, pins});
    if (use_sdo) chk({tag, "_sdo"}, {16'h0, bus.SD_o}, {16'h0, sdo});
  endtask

  task automatic tick();
    @(posedge clk40m);
    #1;
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] be,
                       input logic [15:0] d);
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_be    = be;
    bus.req_wdata = d;
    bus.req_valid = 1'b1;
  endtask

  // Bus invariants checked every cycle outside reset.
  always @(negedge clk40m) begin
    if (RST === 1'b0) begin
      chk("no_dual_strobe", {31'h0, (!bus.RDN && !bus.WRN)}, 32'h0);
      chk("oe_during_rd",  {31'h0, (!bus.RDN && bus.SD_oe)}, 32'h0);
    end
  end

  initial begin
    int i;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_be    = 4'h0;
    bus.req_wdata = 16'h0000;
    bus.INTRN     = 1'b1;

    // Reset values
    repeat (3) tick();
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", {16'h0, bus.rsp_rdata}, 32'h0);
    chk("rst_irq",       {31'h0, bus.irq},       32'h0);
    chk("rst_csn",       {31'h0, bus.CSN},       32'h0);
    chk_bus("rst", 4'b1110, 16'h0000, 1);
    RST = 1'b0;
    tick();
    tick();

    // Write: addr 0x10, be 0011, data 0x89AB
    issue(1'b1, 8'h10, 4'b0011, 16'h89AB);
    tick();
    bus.req_valid = 1'b0;
    chk("wr_busy", {31'h0, bus.req_ready}, 32'h0);
    chk_bus("wr_cmd1", 4'b1011, 16'h3010, 1);
    tick(); chk_bus("wr_cmd2", 4'b1011, 16'h3010, 1);
    tick(); chk_bus("wr_hold", 4'b1111, 16'h3010, 1);
    tick(); chk_bus("wr_gap",  4'b0111, 16'h89AB, 1);
    tick(); chk_bus("wr_dat1", 4'b0011, 16'h89AB, 1);
    tick(); chk_bus("wr_dat2", 4'b0011, 16'h89AB, 1);
    tick(); chk_bus("wr_rec",  4'b0111, 16'h89AB, 1);
    chk("wr_rsp_k7", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    chk("wr_rsp_k8", {31'h0, bus.rsp_valid}, 32'h1);
    chk("wr_ready_k8", {31'h0, bus.req_ready}, 32'h1);
    chk_bus("wr_idle", 4'b1110, 16'h0, 0);
    tick();
    chk("wr_rsp_k9", {31'h0, bus.rsp_valid}, 32'h0);

    // Read: addr 0xC0, be 0011, bus returns 0x8872
    rd_val = 16'h8872;
    issue(1'b0, 8'hC0, 4'b0011, 16'h0000);
    tick();
    bus.req_valid = 1'b0;
    chk_bus("rd_cmd1", 4'b1011, 16'h30C0, 1);
    tick(); chk_bus("rd_cmd2", 4'b1011, 16'h30C0, 1);
    tick(); chk_bus("rd_hold", 4'b1111, 16'h30C0, 1);
    tick(); chk_bus("rd_gap",  4'b0110, 16'h0, 0);
    tick(); chk_bus("rd_dat1", 4'b0100, 16'h0, 0);
    tick(); chk_bus("rd_dat2", 4'b0100, 16'h0, 0);
    tick(); chk_bus("rd_rec",  4'b0110, 16'h0, 0);
    chk("rd_rsp_k7", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    chk("rd_rsp_k8", {31'h0, bus.rsp_valid}, 32'h1);
    chk("rd_rdata",  {16'h0, bus.rsp_rdata}, 32'h8872);
    tick();
    chk("rd_rsp_k9", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rd_rdata_hold", {16'h0, bus.rsp_rdata}, 32'h8872);

    // Back-to-back: read (0x04, be 1111) then write (0x08, be 1100, 0xBEEF)
    rd_val = 16'h55AA;
    issue(1'b0, 8'h04, 4'b1111, 16'h0000);
    tick();
    issue(1'b1, 8'h08, 4'b1100, 16'hBEEF);
    chk("b2b_busy", {31'h0, bus.req_ready}, 32'h0);
    chk_bus("b2b_rd_cmd", 4'b1011, 16'hF004, 1);
    repeat (6) tick();
    chk("b2b_rsp_k7", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    chk("b2b_rd_rsp", {31'h0, bus.rsp_valid}, 32'h1);
    chk("b2b_rd_rdata", {16'h0, bus.rsp_rdata}, 32'h55AA);
    chk("b2b_ready", {31'h0, bus.req_ready}, 32'h1);
    tick();
    bus.req_valid = 1'b0;
    chk_bus("b2b_wr_cmd", 4'b1011, 16'hC008, 1);
    chk("b2b_rsp_low", {31'h0, bus.rsp_valid}, 32'h0);
    repeat (4) tick();
    chk_bus("b2b_wr_dat", 4'b0011, 16'hBEEF, 1);
    repeat (3) tick();
    chk("b2b_wr_rsp", {31'h0, bus.rsp_valid}, 32'h1);
    chk("b2b_rdata_kept", {16'h0, bus.rsp_rdata}, 32'h55AA);

    // req_valid toggled while busy with different fields
    tick();
    issue(1'b1, 8'h20, 4'b1111, 16'h1234);
    tick();
    issue(1'b0, 8'h44, 4'b0001, 16'hFFFF);
    chk_bus("tog_cmd1", 4'b1011, 16'hF020, 1);
    bus.req_valid = 1'b0;
    tick(); bus.req_valid = 1'b1;
    tick(); chk_bus("tog_hold", 4'b1111, 16'hF020, 1); bus.req_valid = 1'b0;
    tick(); chk_bus("tog_gap",  4'b0111, 16'h1234, 1); bus.req_valid = 1'b1;
    tick(); chk_bus("tog_dat1", 4'b0011, 16'h1234, 1); bus.req_valid = 1'b0;
    tick(); chk_bus("tog_dat2", 4'b0011, 16'h1234, 1);
    tick();
    tick();
    chk("tog_rsp", {31'h0, bus.rsp_valid}, 32'h1);
    tick();
    chk_bus("tog_idle1", 4'b1110, 16'h0, 0);
    chk("tog_rsp_low", {31'h0, bus.rsp_valid}, 32'h0);
    tick();
    chk_bus("tog_idle2", 4'b1110, 16'h0, 0);
    chk("tog_ready", {31'h0, bus.req_ready}, 32'h1);

    // Interrupt synchronizer
    chk("irq_idle", {31'h0, bus.irq}, 32'h0);
    bus.INTRN = 1'b0;
    for (i = 0; i < 3 && bus.irq !== 1'b1; i++) tick();
    chk("irq_rise", {31'h0, bus.irq}, 32'h1);
    bus.INTRN = 1'b1;
    for (i = 0; i < 3 && bus.irq !== 1'b0; i++) tick();
    chk("irq_fall", {31'h0, bus.irq}, 32'h0);

    // Asynchronous reset in the middle of DATA_RD
    rd_val = 16'h1111;
    issue(1'b0, 8'h30, 4'b0011, 16'h0000);
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();
    chk("arst_in_rd", {31'h0, bus.RDN}, 32'h0);
    #3 RST = 1'b1;
    #1;
    chk_bus("arst_pins", 4'b1110, 16'h0000, 1);
    chk("arst_ready", {31'h0, bus.req_ready}, 32'h1);
    tick();
    RST = 1'b0;
    chk("arst_rdata", {16'h0, bus.rsp_rdata}, 32'h0);
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("arst_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    end
    chk_bus("arst_idle", 4'b1110, 16'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
